pwm_core: RTL and testbench
===========================

Name: pwm_core

Overview:
- Carrier counter and duty comparator that generates the complementary switch-pair command SPDT[1:0].
- SPDT feeds the downstream dead-time stage directly. This block inserts no dead time.
- Supports edge-aligned and center-aligned carriers.
- Period, duty and mode are double-buffered in shadow registers and update only at period boundaries, so a running waveform never glitches.

Parameters:
- BIT_WIDTH, 16, width of the period, duty and count values.

Ports:
- MClk  in  1  system clock, all logic on posedge
- Rst  in  1  synchronous, active-high reset
- Enable  in  1  run the carrier; 0 = stop and park the outputs
- Period  in  BIT_WIDTH  live period value P (terminal count)
- Duty  in  BIT_WIDTH  live duty compare value D
- CenterAlign  in  1  live mode: 0 = edge-aligned, 1 = center-aligned
- Load  in  1  arm a shadow update at the next boundary
- SPDT  out  2  [0] = high-side command, [1] = low-side command
- PeriodStart  out  1  1-cycle pulse, aligned with the first SPDT cycle of each period
- LoadAck  out  1  1-cycle pulse in the cycle the shadow registers update
- Count  out  BIT_WIDTH  current carrier count, for debug

Behaviour:
- Reset (Rst=1): state IDLE; Count=0; shadow regs=0; pending=0; SPDT=2'b00; PeriodStart=0; LoadAck=0.
- Rst has priority over all other inputs, including mid-period.
- FSM states: IDLE, UP, DOWN.
- IDLE
  - Count=0, SPDT=00.
  - On Enable=1: load shadows from live Period, Duty and CenterAlign; clear pending; go to UP with Count=0; pulse LoadAck.
- Edge mode (shadow mode=0)
  - UP only; Count runs 0..Psh, then wraps to 0.
  - Period length = Psh+1 cycles.
- Center mode (shadow mode=1)
  - UP runs 0..Psh, then DOWN runs Psh-1..1, then back to UP at 0.
  - Period length = 2*Psh cycles.
  - Psh=0 or Psh=1: period is 1 or 2 cycles, with no DOWN state when Psh=0.
- Boundary: the cycle whose next Count is 0.
  - At a boundary with pending=1, or Load=1 that same cycle, shadows load from the live inputs sampled in that cycle.
  - Pending then clears and LoadAck pulses that cycle.
  - New values take effect from Count=0 of the next period.
- Load outside a boundary sets pending. Repeated Loads are idempotent. Values are sampled at the boundary, not at Load.
- Compare: pwm = (Count < Dsh), unsigned, full width, no overflow possible.
  - Edge mode high time = min(Dsh, Psh+1).
  - Center mode high time = 0 if Dsh=0, else min(2*Dsh-1, 2*Psh).
  - Dsh=0 gives 0% duty; Dsh>Psh gives 100% duty.
- Outputs are registered with 1-cycle latency from Count.
  - SPDT = {~pwm, pwm} while running.
  - PeriodStart=1 in the cycle SPDT reflects Count=0.
- Enable=0 while running: next cycle goes to IDLE, Count=0, SPDT=00. Pending is discarded, because the next enable reloads the shadows.
- SPDT is never 2'b11.

Decomposition:
- Package pwm_pkg holds:
  - the state enum (IDLE, UP, DOWN);
  - the SPDT encoding constants SPDT_OFF=2'b00, SPDT_HI=2'b01, SPDT_LO=2'b10.
- The dead-time stage also imports the SPDT constants from pwm_pkg.
- Sub-module pwm_shadow_regs holds the pending flag and the shadow registers for Period, Duty and mode, with a boundary-load strobe.
- The counter/FSM and comparator stay in pwm_core.

Test Plan:
- Edge mode basic. Rst then Enable=1, P=9, D=3, CenterAlign=0. Expect a 10-cycle period; SPDT=01 for 3 cycles and 10 for 7 cycles; PeriodStart every 10 cycles; SPDT=00 before enable.
- Center mode. P=8, D=3, CenterAlign=1. Expect a 16-cycle period; SPDT=01 for 5 cycles, centered on Count=0; Count sequence 0..8..1.
- Shadow update. Running with P=9, D=3; pulse Load at Count=4 with D=7. Expect the current period unchanged; LoadAck at the Count=9 cycle; the next period has 7 high cycles. Also pulse Load at the boundary cycle itself: it must apply the same cycle.
- Extremes. D=0 gives SPDT constantly 10. D=10 with P=9 gives constantly 01. Edge mode with P=0 gives a 1-cycle period and PeriodStart high every cycle.
- Disable and reset mid-period. Drop Enable at Count=5: next cycle SPDT=00, Count=0; re-enable restarts at Count=0 with fresh shadows. Assert Rst mid-DOWN: next cycle all outputs return to reset values.
- Assertions throughout all tests: SPDT!=11; LoadAck and PeriodStart are single-cycle pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and switch-pair command constants for the PWM path
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } pwm_state_e;

  localparam logic [1:0] SPDT_OFF = 2'b00;
  localparam logic [1:0] SPDT_HI  = 2'b01;
  localparam logic [1:0] SPDT_LO  = 2'b10;

endpackage

// File: rtl/pwm_if.sv
// rtl/pwm_if.sv - live configuration and waveform outputs of the PWM carrier
interface pwm_if #(
  parameter int BIT_WIDTH = 16
) ();

  logic                 Enable;
  logic [BIT_WIDTH-1:0] Period;
  logic [BIT_WIDTH-1:0] Duty;
  logic                 CenterAlign;
  logic                 Load;
  logic [1:0]           SPDT;
  logic                 PeriodStart;
  logic                 LoadAck;
  logic [BIT_WIDTH-1:0] Count;

  modport master (
    output Enable, Period, Duty, CenterAlign, Load,
    input  SPDT, PeriodStart, LoadAck, Count
  );

  modport slave (
    input  Enable, Period, Duty, CenterAlign, Load,
    output SPDT, PeriodStart, LoadAck, Count
  );

endinterface

// File: rtl/pwm_shadow_regs.sv
// rtl/pwm_shadow_regs.sv - double-buffered period/duty/mode with a pending-load flag
module pwm_shadow_regs #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 MClk,
  input  logic                 Rst,
  input  logic                 load_strobe,
  input  logic                 load_req,
  input  logic                 clear,
  input  logic [BIT_WIDTH-1:0] period_in,
  input  logic [BIT_WIDTH-1:0] duty_in,
  input  logic                 mode_in,
  output logic [BIT_WIDTH-1:0] period_sh,
  output logic [BIT_WIDTH-1:0] duty_sh,
  output logic                 mode_sh,
  output logic                 pending
);

  // The strobe wins over clear/request so a Load in the boundary cycle applies immediately.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      period_sh <= '0;
      duty_sh   <= '0;
      mode_sh   <= 1'b0;
      pending   <= 1'b0;
    end else if (load_strobe) begin
      period_sh <= period_in;
      duty_sh   <= duty_in;
      mode_sh   <= mode_in;
      pending   <= 1'b0;
    end else if (clear) begin
      pending   <= 1'b0;
    end else if (load_req) begin
      pending   <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - edge/center-aligned carrier counter and duty comparator driving SPDT
module pwm_core
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input logic  MClk,
  input logic  Rst,
  pwm_if.slave bus
);

  pwm_state_e           state_q, state_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic [1:0]           spdt_q, spdt_d;
  logic                 pstart_q, pstart_d;
  logic [BIT_WIDTH-1:0] period_sh, duty_sh;
  logic                 mode_sh, pending;
  logic                 boundary, running, load_strobe, pwm;

  pwm_shadow_regs #(.BIT_WIDTH(BIT_WIDTH)) u_shadow (
    .MClk        (MClk),
    .Rst         (Rst),
    .load_strobe (load_strobe),
    .load_req    (bus.Load),
    .clear       (~bus.Enable),
    .period_in   (bus.Period),
    .duty_in     (bus.Duty),
    .mode_in     (bus.CenterAlign),
    .period_sh   (period_sh),
    .duty_sh     (duty_sh),
    .mode_sh     (mode_sh),
    .pending     (pending)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    boundary = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.Enable) state_d = UP;
      end
      UP: begin
        if (count_q >= period_sh) begin
          // Psh of 0 or 1 has no down-slope: the period closes at the top.
          if (mode_sh && (period_sh >= BIT_WIDTH'(2))) begin
            state_d = DOWN;
            count_d = period_sh - BIT_WIDTH'(1);
          end else begin
            count_d  = '0;
            boundary = 1'b1;
          end
        end else begin
          count_d = count_q + BIT_WIDTH'(1);
        end
      end
      DOWN: begin
        if (count_q <= BIT_WIDTH'(1)) begin
          state_d  = UP;
          count_d  = '0;
          boundary = 1'b1;
        end else begin
          count_d = count_q - BIT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    if (!bus.Enable) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  assign running     = (state_q != IDLE);
  assign load_strobe = !Rst && bus.Enable && (!running || (boundary && (pending || bus.Load)));
  assign pwm         = (count_q < duty_sh);
  assign spdt_d      = (running && bus.Enable) ? (pwm ? SPDT_HI : SPDT_LO) : SPDT_OFF;
  assign pstart_d    = running && bus.Enable && (state_q == UP) && (count_q == '0);

  always_ff @(posedge MClk) begin
    if (Rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      spdt_q   <= SPDT_OFF;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      spdt_q   <= spdt_d;
      pstart_q <= pstart_d;
    end
  end

  assign bus.SPDT        = spdt_q;
  assign bus.PeriodStart = pstart_q;
  assign bus.LoadAck     = load_strobe;
  assign bus.Count       = count_q;

endmodule

// File: tb/tb_pwm_core.sv
// tb/tb_pwm_core.sv - cycle-table bench for pwm_core
module tb_pwm_core;
  import pwm_pkg::*;

  localparam int BW = 16;

  logic MClk = 1'b0;
  logic Rst  = 1'b1;
  always #5 MClk = ~MClk;

  pwm_if #(.BIT_WIDTH(BW)) bus ();
  pwm_core #(.BIT_WIDTH(BW)) dut (.MClk(MClk), .Rst(Rst), .bus(bus));

  typedef struct {
    bit          rst, en, ca, ld, rpt;
    logic [BW-1:0] per, duty;
    logic [1:0]  spdt;
    bit          ps, la;
    logic [BW-1:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  bit   cur_rpt = 1'b0;
  bit   prev_ps = 1'b0;
  bit   prev_la = 1'b0;

  function automatic logic [1:0] hi_lo(bit b);
    return b ? SPDT_HI : SPDT_LO;
  endfunction

  function automatic void push(bit rst, bit en, int per, int duty, bit ca, bit ld,
                               logic [1:0] spdt, bit ps, bit la, int cnt, bit rpt);
    vec_t v;
    v.rst = rst; v.en = en; v.ca = ca; v.ld = ld; v.rpt = rpt;
    v.per = per[BW-1:0]; v.duty = duty[BW-1:0];
    v.spdt = spdt; v.ps = ps; v.la = la; v.cnt = cnt[BW-1:0];
    vq.push_back(v);
  endfunction

  // Enable cycle, nj running cycles, one disable cycle, one idle cycle.
  function automatic void edge_seg(int p, int d, int nj, bit rpt);
    int m;
    push(0, 1, p, d, 0, 0, SPDT_OFF, 0, 1, 0, rpt);
    for (int j = 1; j <= nj + 1; j++) begin
      m = (j >= 2) ? (j - 2) % (p + 1) : -1;
      push(0, j <= nj, p, d, 0, 0, (j < 2) ? SPDT_OFF : hi_lo(m < d),
           m == 0, 0, (j - 1) % (p + 1), rpt);
    end
    push(0, 0, p, d, 0, 0, SPDT_OFF, 0, 0, 0, 0);
  endfunction

  function automatic int ccnt(int t, int p);
    return (t <= p) ? t : 2 * p - t;
  endfunction

  function automatic void center_seg(int p, int d, int nj);
    int t;
    push(0, 1, p, d, 1, 0, SPDT_OFF, 0, 1, 0, 0);
    for (int j = 1; j <= nj + 1; j++) begin
      t = (j >= 2) ? (j - 2) % (2 * p) : -1;
      push(0, j <= nj, p, d, 1, 0, (j < 2) ? SPDT_OFF : hi_lo(ccnt(t, p) < d),
           t == 0, 0, ccnt((j - 1) % (2 * p), p), 0);
    end
    push(0, 0, p, d, 1, 0, SPDT_OFF, 0, 0, 0, 0);
  endfunction

  // Load mid-period at Count=4 (duty changes after Load), then Load in a boundary cycle.
  function automatic void shadow_seg();
    int  m, dsh, dl;
    bit  ld;
    push(0, 1, 9, 3, 0, 0, SPDT_OFF, 0, 1, 0, 0);
    for (int j = 1; j <= 33; j++) begin
      ld  = (j == 5) || (j == 20);
      dl  = (j < 5) ? 3 : (j == 5) ? 5 : (j < 20) ? 7 : 2;
      m   = (j >= 2) ? (j - 2) % 10 : -1;
      dsh = (j < 12) ? 3 : (j < 22) ? 7 : 2;
      push(0, j <= 32, 9, dl, 0, ld, (j < 2) ? SPDT_OFF : hi_lo(m < dsh),
           m == 0, (j == 10) || (j == 20), (j - 1) % 10, 0);
    end
    push(0, 0, 9, 2, 0, 0, SPDT_OFF, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input int per, input int duty,
                       input bit ca, input bit ld);
    Rst = rst; bus.Enable = en; bus.Period = per[BW-1:0]; bus.Duty = duty[BW-1:0];
    bus.CenterAlign = ca; bus.Load = ld;
  endtask

  always @(negedge MClk) begin
    #2;
    checks++;
    if (bus.SPDT == 2'b11) begin
      errors++;
      $display("FAIL spdt_not_11 actual=%b required=not 11", bus.SPDT);
    end
    if (prev_ps && !cur_rpt) begin
      checks++;
      if (bus.PeriodStart) begin
        errors++;
        $display("FAIL periodstart_pulse actual=1 required=0");
      end
    end
    if (prev_la) begin
      checks++;
      if (bus.LoadAck) begin
        errors++;
        $display("FAIL loadack_pulse actual=1 required=0");
      end
    end
    prev_ps = bus.PeriodStart;
    prev_la = bus.LoadAck;
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    push(1, 1, 9, 3, 0, 0, SPDT_OFF, 0, 0, 0, 0);
    push(1, 1, 9, 3, 0, 0, SPDT_OFF, 0, 0, 0, 0);
    push(0, 0, 9, 3, 0, 0, SPDT_OFF, 0, 0, 0, 0);
    push(0, 0, 9, 3, 0, 0, SPDT_OFF, 0, 0, 0, 0);
    edge_seg(9, 3, 25, 0);
    edge_seg(9, 6, 22, 0);
    shadow_seg();
    edge_seg(9, 0, 15, 0);
    edge_seg(9, 10, 15, 0);
    edge_seg(0, 1, 8, 1);
    center_seg(8, 3, 34);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge MClk);
      cur_rpt = vq[i].rpt;
      drive(vq[i].rst, vq[i].en, int'(vq[i].per), int'(vq[i].duty), vq[i].ca, vq[i].ld);
      #1;
      check($sformatf("v%0d spdt", i),   bus.SPDT,        vq[i].spdt);
      check($sformatf("v%0d pstart", i), bus.PeriodStart, vq[i].ps);
      check($sformatf("v%0d loadack", i), bus.LoadAck,    vq[i].la);
      check($sformatf("v%0d count", i),  bus.Count,       vq[i].cnt);
    end

    // Reset while the center carrier is on its down-slope.
    cur_rpt = 1'b0;
    @(negedge MClk);
    drive(0, 1, 8, 3, 1, 0);
    #1 check("rst_seq enable_ack", bus.LoadAck, 1);
    repeat (12) @(negedge MClk);
    #1;
    check("rst_seq down_count", bus.Count, 5);
    check("rst_seq down_spdt", bus.SPDT, SPDT_LO);
    @(negedge MClk);
    drive(1, 1, 8, 3, 1, 1);
    #1;
    check("rst_seq ack_gated", bus.LoadAck, 0);
    check("rst_seq count_held", bus.Count, 4);
    @(negedge MClk);
    #1;
    check("rst_seq count_reset", bus.Count, 0);
    check("rst_seq spdt_reset", bus.SPDT, SPDT_OFF);
    check("rst_seq pstart_reset", bus.PeriodStart, 0);
    check("rst_seq ack_reset", bus.LoadAck, 0);
    @(negedge MClk);
    drive(0, 1, 8, 3, 1, 0);
    #1 check("rst_seq restart_ack", bus.LoadAck, 1);
    @(negedge MClk);
    #1;
    check("rst_seq first_up_count", bus.Count, 0);
    check("rst_seq first_up_spdt", bus.SPDT, SPDT_OFF);
    @(negedge MClk);
    #1;
    check("rst_seq second_count", bus.Count, 1);
    check("rst_seq second_spdt", bus.SPDT, SPDT_HI);
    check("rst_seq second_pstart", bus.PeriodStart, 1);

    @(negedge MClk);
    drive(0, 0, 0, 0, 0, 0);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
